// File: rtl/branch_condition_unit.sv
// branch_condition_unit
//   Consumer end of the 18-bit magnitude comparator. It keeps the last one-hot
//   compare result in a flag register, accepts one conditional branch at a
//   time, resolves the branch condition against those flags and presents the
//   next PC to fetch over a valid/ready handshake.
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   cmp_valid/equal/greater/less comparator result strobe and flags
//   br_valid/ready/cond/target/fallthru  branch request handshake
//   redir_valid/ready/addr/taken         redirect handshake toward fetch
//   flags_valid, flag_eq/gt/lt  flag register state
//   err_flags                   sticky: a compare strobe was not one-hot
module branch_condition_unit #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmp_valid,
  input  logic              cmp_equal,
  input  logic              cmp_greater,
  input  logic              cmp_less,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] br_fallthru,
  output logic              redir_valid,
  input  logic              redir_ready,
  output logic [ADDR_W-1:0] redir_addr,
  output logic              redir_taken,
  output logic              flags_valid,
  output logic              flag_eq,
  output logic              flag_gt,
  output logic              flag_lt,
  output logic              err_flags
);

  localparam logic [2:0] C_ALW = 3'd0, C_EQ = 3'd1, C_NE = 3'd2, C_GT = 3'd3,
                         C_LT  = 3'd4, C_GE = 3'd5, C_LE = 3'd6, C_NEV = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_WAIT_FLAGS, S_REDIRECT} state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_cond;
  logic [ADDR_W-1:0]   r_target, r_fallthru;
  logic                r_flags_valid, r_eq, r_gt, r_lt, r_err;
  logic                r_redir_valid, r_redir_taken;
  logic [ADDR_W-1:0]   r_redir_addr;

  logic w_cmp_onehot, w_cmp_ok, w_br_fire, w_needs_flags, w_taken;
  logic w_capture, w_redir_load, w_redir_clr;

  // exactly one of three bits set: odd parity rules out 0 and 2, and the AND
  // rules out all three
  assign w_cmp_onehot = (cmp_equal ^ cmp_greater ^ cmp_less) &
                        ~(cmp_equal & cmp_greater & cmp_less);
  assign w_cmp_ok     = cmp_valid & w_cmp_onehot;

  assign br_ready      = (r_state == S_IDLE) & rst_n;
  assign w_br_fire     = br_valid & br_ready;
  assign w_needs_flags = (r_cond != C_ALW) && (r_cond != C_NEV);

  always_comb begin
    w_taken = 1'b0;
    case (r_cond)
      C_ALW:   w_taken = 1'b1;
      C_EQ:    w_taken = r_eq;
      C_NE:    w_taken = ~r_eq;
      C_GT:    w_taken = r_gt;
      C_LT:    w_taken = r_lt;
      C_GE:    w_taken = r_gt | r_eq;
      C_LE:    w_taken = r_lt | r_eq;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_capture    = 1'b0;
    w_redir_load = 1'b0;
    w_redir_clr  = 1'b0;
    case (r_state)
      S_IDLE: if (w_br_fire) begin
        w_capture   = 1'b1;
        w_state_nxt = S_EVAL;
      end
      S_EVAL: if (w_needs_flags && !r_flags_valid) begin
        w_state_nxt = S_WAIT_FLAGS;
      end else begin
        w_redir_load = 1'b1;
        w_state_nxt  = S_REDIRECT;
      end
      // the new flags land at the same edge, so EVAL sees them next cycle
      S_WAIT_FLAGS: if (w_cmp_ok) w_state_nxt = S_EVAL;
      S_REDIRECT: if (redir_ready) begin
        w_redir_clr = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cond        <= C_ALW;
      r_target      <= '0;
      r_fallthru    <= '0;
      r_flags_valid <= 1'b0;
      r_eq          <= 1'b0;
      r_gt          <= 1'b0;
      r_lt          <= 1'b0;
      r_err         <= 1'b0;
      r_redir_valid <= 1'b0;
      r_redir_taken <= 1'b0;
      r_redir_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // flag register tracks the comparator in every state
      if (w_cmp_ok) begin
        r_flags_valid <= 1'b1;
        r_eq          <= cmp_equal;
        r_gt          <= cmp_greater;
        r_lt          <= cmp_less;
      end else if (cmp_valid) begin
        r_err <= 1'b1;
      end
      if (w_capture) begin
        r_cond     <= br_cond;
        r_target   <= br_target;
        r_fallthru <= br_fallthru;
      end
      if (w_redir_load) begin
        r_redir_valid <= 1'b1;
        r_redir_taken <= w_taken;
        r_redir_addr  <= w_taken ? r_target : r_fallthru;
      end else if (w_redir_clr) begin
        r_redir_valid <= 1'b0;
      end
    end
  end

  assign redir_valid = r_redir_valid;
  assign redir_addr  = r_redir_addr;
  assign redir_taken = r_redir_taken;
  assign flags_valid = r_flags_valid;
  assign flag_eq     = r_eq;
  assign flag_gt     = r_gt;
  assign flag_lt     = r_lt;
  assign err_flags   = r_err;

endmodule

// File: tb/tb_branch_condition_unit.sv
module tb_branch_condition_unit;
  logic        clk = 0, rst_n = 0;
  logic        cmp_valid = 0, cmp_equal = 0, cmp_greater = 0, cmp_less = 0;
  logic        br_valid = 0, br_ready;
  logic [2:0]  br_cond = 0;
  logic [17:0] br_target = 0, br_fallthru = 0;
  logic        redir_valid, redir_ready = 0, redir_taken;
  logic [17:0] redir_addr;
  logic        flags_valid, flag_eq, flag_gt, flag_lt, err_flags;

  branch_condition_unit #(.ADDR_W(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmp_valid(cmp_valid), .cmp_equal(cmp_equal), .cmp_greater(cmp_greater), .cmp_less(cmp_less),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
    .br_target(br_target), .br_fallthru(br_fallthru),
    .redir_valid(redir_valid), .redir_ready(redir_ready),
    .redir_addr(redir_addr), .redir_taken(redir_taken),
    .flags_valid(flags_valid), .flag_eq(flag_eq), .flag_gt(flag_gt), .flag_lt(flag_lt),
    .err_flags(err_flags));

  always #5 clk = ~clk;

  int n_pass = 0, n_chk = 0;

  // reference: last valid comparison as a relation (0 eq, 1 gt, 2 lt)
  bit m_fv, m_err;
  int m_rel;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic bit exp_taken(int c);
    case (c)
      0: return 1;
      1: return m_rel == 0;
      2: return m_rel != 0;
      3: return m_rel == 1;
      4: return m_rel == 2;
      5: return m_rel == 1 || m_rel == 0;
      6: return m_rel == 2 || m_rel == 0;
      default: return 0;
    endcase
  endfunction

  function automatic void model_cmp(bit e, bit g, bit l);
    if (int'(e) + int'(g) + int'(l) == 1) begin
      m_fv  = 1;
      m_rel = e ? 0 : (g ? 1 : 2);
    end else m_err = 1;
  endfunction

  task automatic chk_flags();
    chk("flags_valid", flags_valid, m_fv);
    chk("flags", {flag_eq, flag_gt, flag_lt},
        m_fv ? {m_rel == 0, m_rel == 1, m_rel == 2} : 3'b000);
    chk("err_flags", err_flags, m_err);
  endtask

  task automatic do_reset();
    rst_n = 0; br_valid = 0; cmp_valid = 0; redir_ready = 0;
    tick(); tick();
    m_fv = 0; m_err = 0; m_rel = 0;
    chk("rst_redir_valid", redir_valid, 0);
    chk("rst_redir_addr", redir_addr, 0);
    chk("rst_redir_taken", redir_taken, 0);
    chk("rst_br_ready", br_ready, 0);
    chk_flags();
    rst_n = 1; #1;
    chk("rel_br_ready", br_ready, 1);
  endtask

  task automatic do_cmp(bit e, bit g, bit l);
    cmp_valid = 1; cmp_equal = e; cmp_greater = g; cmp_less = l;
    tick();
    cmp_valid = 0;
    model_cmp(e, g, l);
    chk_flags();
  endtask

  // with_cmp: drive a one-hot compare (relation wr) in the handshake cycle;
  // a branch that must wait for flags is released by a compare of relation wr
  task automatic do_branch(int c, logic [17:0] t, logic [17:0] f,
                           bit with_cmp, int wr, int delay);
    logic [17:0] ea;
    bit et, needwait;
    redir_ready = (delay == 0);
    chk("idle_br_ready", br_ready, 1);
    br_valid = 1; br_cond = 3'(c); br_target = t; br_fallthru = f;
    if (with_cmp) begin
      cmp_valid = 1; cmp_equal = (wr == 0); cmp_greater = (wr == 1); cmp_less = (wr == 2);
    end
    tick();
    br_valid = 0; cmp_valid = 0;
    if (with_cmp) model_cmp(wr == 0, wr == 1, wr == 2);
    chk("eval_redir_valid", redir_valid, 0);
    chk("eval_br_ready", br_ready, 0);
    needwait = (c != 0 && c != 7 && !m_fv);
    if (needwait) begin
      repeat (3) begin
        tick();
        chk("wait_redir_valid", redir_valid, 0);
        chk("wait_br_ready", br_ready, 0);
      end
      cmp_valid = 1; cmp_equal = (wr == 0); cmp_greater = (wr == 1); cmp_less = (wr == 2);
      tick();
      cmp_valid = 0;
      model_cmp(wr == 0, wr == 1, wr == 2);
      chk("rewake_redir_valid", redir_valid, 0);
    end
    et = exp_taken(c);
    ea = et ? t : f;
    tick();
    chk("redir_valid", redir_valid, 1);
    chk("redir_addr", redir_addr, ea);
    chk("redir_taken", redir_taken, et);
    // a second request offered while the redirect is stalled must be ignored
    for (int i = 0; i < delay; i++) begin
      br_valid = 1; br_cond = 3'd0; br_target = ~t; br_fallthru = ~f;
      tick();
      chk("hold_valid", redir_valid, 1);
      chk("hold_addr", redir_addr, ea);
      chk("hold_taken", redir_taken, et);
      chk("hold_br_ready", br_ready, 0);
    end
    br_valid = 0;
    redir_ready = 1;
    tick();
    redir_ready = 0;
    chk("done_redir_valid", redir_valid, 0);
    chk("done_br_ready", br_ready, 1);
  endtask

  initial begin
    do_reset();
    // equal flags, EQ branch taken
    do_cmp(1, 0, 0);
    do_branch(1, 18'h2A000, 18'h00101, 0, 0, 0);
    // greater flags: LE not taken, GE taken
    do_cmp(0, 1, 0);
    do_branch(6, 18'h3FFFF, 18'h00004, 0, 0, 0);
    do_branch(5, 18'h3FFFF, 18'h00004, 0, 0, 0);
    // LT before any compare waits, then released by lt
    do_reset();
    do_branch(4, 18'h12345, 18'h00F00, 0, 2, 0);
    // ALW / NEV need no flags
    do_reset();
    do_branch(0, 18'h00AAA, 18'h00555, 0, 0, 0);
    do_branch(7, 18'h00AAA, 18'h00555, 0, 0, 0);
    // non-one-hot strobe: sticky error, flags unchanged
    do_cmp(0, 0, 1);
    do_cmp(1, 1, 0);
    do_cmp(0, 0, 0);
    do_branch(0, 18'h01111, 18'h02222, 0, 0, 0);
    do_branch(7, 18'h01111, 18'h02222, 0, 0, 0);
    // stalled redirect
    do_branch(3, 18'h20000, 18'h00010, 0, 0, 5);
    // compare in the handshake cycle is forwarded to EVAL
    do_reset();
    do_branch(1, 18'h00777, 18'h00888, 1, 0, 0);
    do_branch(2, 18'h00777, 18'h00888, 1, 1, 2);

    // reset while a redirect is pending
    do_cmp(0, 0, 1);
    br_valid = 1; br_cond = 3'd0; br_target = 18'h3ABCD; br_fallthru = 18'h0;
    tick();
    br_valid = 0;
    tick();
    chk("pre_rst_valid", redir_valid, 1);
    rst_n = 0;
    tick();
    m_fv = 0; m_err = 0;
    chk("midrst_redir_valid", redir_valid, 0);
    chk("midrst_br_ready", br_ready, 0);
    chk_flags();
    rst_n = 1; #1;
    chk("midrst_rel_br_ready", br_ready, 1);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      int r = $urandom_range(0, 19);
      if (r == 0) do_reset();
      else if (r < 7) begin
        int k = $urandom_range(0, 7);
        if (k < 6) begin
          int rel = k % 3;
          do_cmp(rel == 0, rel == 1, rel == 2);
        end else do_cmp(1'($urandom), 1'($urandom), 1'($urandom));
      end else
        do_branch($urandom_range(0, 7), 18'($urandom), 18'($urandom),
                  1'($urandom_range(0, 3) == 0), $urandom_range(0, 2),
                  $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
